// File: rtl/vector_fetch_engine.sv
// Strided vector fetch: issues one element read per cycle, collects the returns
// from a pipelined RAM into a flattened vector and offers it over valid/ready.
module vector_fetch_engine #(
  parameter int ELEMENT_WIDTH = 24,
  parameter int ADDR_WIDTH    = 17,
  parameter int MAX_DIMENSION = 8,
  parameter int MEM_LATENCY   = 1,
  parameter int STRIDE_WIDTH  = 8,
  parameter int DIM_WIDTH     = $clog2(MAX_DIMENSION + 1)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [ADDR_WIDTH-1:0]                  base_addr,
  input  logic [STRIDE_WIDTH-1:0]                stride,
  input  logic [DIM_WIDTH-1:0]                   dimension,
  input  logic [ELEMENT_WIDTH-1:0]               element_in,
  input  logic                                   vector_ready,
  output logic [ADDR_WIDTH-1:0]                  addr,
  output logic                                   rd_en,
  output logic [ELEMENT_WIDTH*MAX_DIMENSION-1:0] vector,
  output logic                                   vector_valid,
  output logic                                   busy,
  output logic                                   error
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

  state_t                  state;
  logic [STRIDE_WIDTH-1:0] stride_q;
  logic [DIM_WIDTH-1:0]    dim_q;
  logic [DIM_WIDTH-1:0]    issue_cnt;
  logic [DIM_WIDTH-1:0]    cap_cnt;
  logic [MEM_LATENCY-1:0]  rd_pipe;

  logic                    cap_fire;
  logic [DIM_WIDTH-1:0]    cap_cnt_nxt;
  logic                    cap_done;
  logic                    dim_ok;

  // Address step wraps modulo 2^ADDR_WIDTH; stride is zero-extended.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [STRIDE_WIDTH-1:0] s);
    return a + ADDR_WIDTH'(s);
  endfunction

  always_comb begin
    cap_fire    = rd_pipe[MEM_LATENCY-1];
    cap_cnt_nxt = cap_cnt + DIM_WIDTH'(cap_fire);
    cap_done    = (cap_cnt_nxt == dim_q);
    dim_ok      = (dimension != '0) && (dimension <= DIM_WIDTH'(MAX_DIMENSION));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      stride_q     <= '0;
      dim_q        <= '0;
      issue_cnt    <= '0;
      cap_cnt      <= '0;
      rd_pipe      <= '0;
      addr         <= '0;
      rd_en        <= 1'b0;
      vector       <= '0;
      vector_valid <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
    end else begin
      error   <= 1'b0;
      // rd_pipe mirrors the RAM latency so its tail marks a valid element_in.
      rd_pipe <= (rd_pipe << 1) | MEM_LATENCY'(rd_en);

      if (cap_fire) begin
        for (int i = 0; i < MAX_DIMENSION; i++) begin
          if (cap_cnt == DIM_WIDTH'(i)) vector[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] <= element_in;
        end
        cap_cnt <= cap_cnt_nxt;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (dim_ok) begin
              stride_q  <= stride;
              dim_q     <= dimension;
              addr      <= base_addr;
              rd_en     <= 1'b1;
              issue_cnt <= DIM_WIDTH'(1);
              cap_cnt   <= '0;
              vector    <= '0;
              busy      <= 1'b1;
              state     <= ISSUE;
            end else begin
              error <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (issue_cnt == dim_q) begin
            rd_en <= 1'b0;
            if (cap_done) begin
              vector_valid <= 1'b1;
              state        <= HOLD;
            end else begin
              state <= DRAIN;
            end
          end else begin
            addr      <= next_addr(addr, stride_q);
            issue_cnt <= issue_cnt + DIM_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (cap_done) begin
            vector_valid <= 1'b1;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (vector_ready) begin
            vector_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_fetch_engine.sv
// Directed bench for vector_fetch_engine: a latency-1 and a latency-3 build share
// stimulus; a monitor pops expected vectors from a scoreboard on each handshake.
module tb_vector_fetch_engine;
  localparam int EW = 24;
  localparam int AW = 17;
  localparam int MD = 8;
  localparam int SW = 8;
  localparam int DW = 4;
  localparam int VW = EW * MD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [SW-1:0] stride;
  logic [DW-1:0] dimension;
  logic          vector_ready;

  logic [EW-1:0] element_in [2];
  logic [AW-1:0] addr_a     [2];
  logic          rd_en_a    [2];
  logic [VW-1:0] vec_a      [2];
  logic          valid_a    [2];
  logic          busy_a     [2];
  logic          error_a    [2];

  int n_tests = 0;
  int n_fail  = 0;
  logic [VW-1:0] exp_q[$];
  int rd_idx[2];

  vector_fetch_engine #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .stride(stride),
    .dimension(dimension), .element_in(element_in[0]), .vector_ready(vector_ready),
    .addr(addr_a[0]), .rd_en(rd_en_a[0]), .vector(vec_a[0]), .vector_valid(valid_a[0]),
    .busy(busy_a[0]), .error(error_a[0]));

  vector_fetch_engine #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .stride(stride),
    .dimension(dimension), .element_in(element_in[1]), .vector_ready(vector_ready),
    .addr(addr_a[1]), .rd_en(rd_en_a[1]), .vector(vec_a[1]), .vector_valid(valid_a[1]),
    .busy(busy_a[1]), .error(error_a[1]));

  function automatic logic [EW-1:0] mem_val(input logic [AW-1:0] a);
    return EW'(a);
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Memory models: garbage when no read is pending so spurious captures show up.
  logic [EW-1:0] m1;
  logic [EW-1:0] m3 [3];
  always @(posedge clk) begin
    m1    <= rd_en_a[0] ? mem_val(addr_a[0]) : 24'hDEAD00;
    m3[0] <= rd_en_a[1] ? mem_val(addr_a[1]) : 24'hDEAD00;
    m3[1] <= m3[0];
    m3[2] <= m3[1];
  end
  assign element_in[0] = m1;
  assign element_in[1] = m3[2];

  task automatic chk(input string name, input int k, input logic [VW-1:0] act,
                     input logic [VW-1:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, k, $time, act, expv);
    end
  endtask

  function automatic logic [VW-1:0] build_vec(input logic [AW-1:0] b, input logic [SW-1:0] s,
                                              input int d);
    logic [VW-1:0] v;
    logic [AW-1:0] a;
    v = '0;
    a = b;
    for (int i = 0; i < d; i++) begin
      v[i*EW +: EW] = mem_val(a);
      a = a + AW'(s);
    end
    return v;
  endfunction

  // Scoreboard monitor: stability while offered, data compare on each handshake.
  logic [VW-1:0] prev_vec   [2];
  logic          prev_valid [2];
  initial begin
    prev_valid[0] = 1'b0;
    prev_valid[1] = 1'b0;
    rd_idx[0] = 0;
    rd_idx[1] = 0;
  end
  always begin
    @(negedge clk);
    #2;
    for (int k = 0; k < 2; k++) begin
      if (valid_a[k] === 1'b1) begin
        if (prev_valid[k]) chk("vector_stable", k, vec_a[k], prev_vec[k]);
        if (vector_ready === 1'b1) begin
          if (rd_idx[k] < exp_q.size()) begin
            chk("vector_data", k, vec_a[k], exp_q[rd_idx[k]]);
            rd_idx[k]++;
          end else begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_handshake dut%0d: got %0h expected none", k, vec_a[k]);
          end
        end
      end
      prev_valid[k] = (valid_a[k] === 1'b1);
      prev_vec[k]   = vec_a[k];
    end
  end

  task automatic do_req(input logic [AW-1:0] b, input logic [SW-1:0] s, input int d,
                        input int hold, input int bsc);
    int r;
    int i;
    logic [AW-1:0] ea;
    r = d + 4 + hold;
    @(negedge clk);
    base_addr = b;
    stride    = s;
    dimension = DW'(d);
    start     = 1'b1;
    exp_q.push_back(build_vec(b, s, d));
    for (int c = 1; c <= r + 1; c++) begin
      @(negedge clk);
      i  = (c <= d) ? c - 1 : d - 1;
      ea = b + AW'(s) * AW'(i);
      for (int k = 0; k < 2; k++) begin
        chk("rd_en", k, VW'(rd_en_a[k]), VW'(c <= d));
        if (c <= r) chk("addr", k, VW'(addr_a[k]), VW'(ea));
        chk("vector_valid", k, VW'(valid_a[k]), VW'((c >= d + lat_of(k) + 1) && (c <= r)));
        chk("busy", k, VW'(busy_a[k]), VW'(c <= r));
        chk("error", k, VW'(error_a[k]), VW'(0));
      end
      start = (c == bsc);
      if (c == bsc) base_addr = 17'h07000;
      vector_ready = (c == r);
    end
    vector_ready = 1'b0;
  endtask

  task automatic bad_dim(input int d);
    @(negedge clk);
    base_addr = 17'h00100;
    dimension = DW'(d);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("error_pulse", k, VW'(error_a[k]), VW'(1));
      chk("bad_busy", k, VW'(busy_a[k]), VW'(0));
      chk("bad_rd_en", k, VW'(rd_en_a[k]), VW'(0));
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("error_clear", k, VW'(error_a[k]), VW'(0));
      chk("bad_busy2", k, VW'(busy_a[k]), VW'(0));
      chk("bad_rd_en2", k, VW'(rd_en_a[k]), VW'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    base_addr = '0;
    stride = '0;
    dimension = '0;
    vector_ready = 1'b0;
    #12;
    for (int k = 0; k < 2; k++) begin
      chk("rst_rd_en", k, VW'(rd_en_a[k]), VW'(0));
      chk("rst_addr", k, VW'(addr_a[k]), VW'(0));
      chk("rst_vector", k, vec_a[k], VW'(0));
      chk("rst_valid", k, VW'(valid_a[k]), VW'(0));
      chk("rst_busy", k, VW'(busy_a[k]), VW'(0));
      chk("rst_error", k, VW'(error_a[k]), VW'(0));
    end
    @(negedge clk);
    reset = 1'b1;

    do_req(17'h00100, 8'd1, 3, 0, 0);
    do_req(17'h1FFFE, 8'd4, 4, 0, 0);
    do_req(17'h00400, 8'd2, 8, 5, 0);
    bad_dim(0);
    bad_dim(9);
    do_req(17'h00500, 8'd3, 4, 0, 2);

    // Abort during the third issue, then confirm a fresh request has no stale slots.
    @(negedge clk);
    base_addr = 17'h00200;
    stride    = 8'd1;
    dimension = 4'd5;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("abort_rd_en_pre", k, VW'(rd_en_a[k]), VW'(1));
      chk("abort_addr_pre", k, VW'(addr_a[k]), VW'(17'h00202));
    end
    reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("abort_rd_en", k, VW'(rd_en_a[k]), VW'(0));
      chk("abort_addr", k, VW'(addr_a[k]), VW'(0));
      chk("abort_vector", k, vec_a[k], VW'(0));
      chk("abort_valid", k, VW'(valid_a[k]), VW'(0));
      chk("abort_busy", k, VW'(busy_a[k]), VW'(0));
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    do_req(17'h00300, 8'd1, 2, 0, 0);

    do_req(17'h01000, 8'd7, 5, 0, 0);
    do_req(17'h00020, 8'd0, 1, 1, 0);

    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("scoreboard_drained", k, VW'(rd_idx[k]), VW'(exp_q.size()));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_fetch_engine.md
Name: vector_fetch_engine

Overview:
- Parametrised successor to the fixed-dimension vector builder.
- Fetches a vector of runtime-selectable length (1..MAX_DIMENSION) from a pipelined element memory: one read per cycle from base_addr with a programmable stride.
- Assembles the returned elements into a flattened vector and hands it to the downstream multiplier datapath over a valid/ready handshake.
- Sits between the element RAM and the vector multiply stage.

Parameters:
- ELEMENT_WIDTH, 24, bits per vector element.
- ADDR_WIDTH, 17, element memory address width.
- MAX_DIMENSION, 8, maximum elements per vector; sets output vector width.
- MEM_LATENCY, 1, cycles from address presented to element_in valid; must be >= 1.
- STRIDE_WIDTH, 8, width of the stride input.
- DIM_WIDTH, $clog2(MAX_DIMENSION+1), width of the dimension input.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  address of element 0; sampled with start.
- stride  input  STRIDE_WIDTH  unsigned address increment between elements; sampled with start.
- dimension  input  DIM_WIDTH  element count; sampled with start.
- element_in  input  ELEMENT_WIDTH  memory read data, valid MEM_LATENCY cycles after rd_en.
- vector_ready  input  1  downstream accepts vector.
- addr  output  ADDR_WIDTH  memory read address, registered.
- rd_en  output  1  memory read strobe, registered.
- vector  output  ELEMENT_WIDTH*MAX_DIMENSION  element i at bits [i*ELEMENT_WIDTH +: ELEMENT_WIDTH].
- vector_valid  output  1  vector complete and held stable.
- busy  output  1  high in any state other than IDLE.
- error  output  1  one-cycle pulse on an illegal dimension.

Behaviour:
- Reset (reset low, asynchronous): all outputs 0, state IDLE, capture pipe cleared, vector cleared.
- FSM states: IDLE, ISSUE, DRAIN, HOLD.
- IDLE, start=1, dimension in 1..MAX_DIMENSION:
  - latch base_addr, stride and dimension (D);
  - clear vector, so slots >= D read as 0;
  - go to ISSUE.
- IDLE, start=1, dimension = 0 or > MAX_DIMENSION: error=1 for the next cycle only; stay in IDLE; no reads.
- ISSUE:
  - rd_en=1 and addr = base_addr + i*stride for i = 0..D-1, one per cycle;
  - address arithmetic is modulo 2^ADDR_WIDTH (wraps silently);
  - after issue i = D-1, go to DRAIN, or directly to HOLD if all captures are done.
- Capture pipe: a MEM_LATENCY-deep shift register carries rd_en. When its output is 1, element_in is written into slot cap_idx and cap_idx increments.
- DRAIN: rd_en=0, addr holds its last value. When capture count reaches D, go to HOLD.
- HOLD:
  - vector_valid=1; vector is stable;
  - when vector_valid and vector_ready are both 1 on an edge, clear vector_valid and return to IDLE;
  - start in that same cycle is ignored; the next request is accepted in IDLE.
- Timing: start sampled at the end of cycle 0 gives rd_en in cycles 1..D, captures in cycles 1+L..D+L, and vector_valid from cycle D+L+1, where L = MEM_LATENCY.
- start while busy=1 is ignored; inputs are not re-sampled.
- vector_ready while not in HOLD is ignored.
- Reset asserted mid-operation:
  - aborts immediately; in-flight returns are discarded;
  - element_in arriving after reset release is not captured.
- busy=1 from the cycle after an accepted start until the cycle after the handshake.

Test Plan:
- L=1, D=3, base=0x00100, stride=1, memory holds mem[a]=a: rd_en in cycles 1..3 with addr 0x100..0x102; vector_valid in cycle 5; slots 0..2 = 0x100, 0x101, 0x102; slots 3..7 = 0; ready=1 returns busy to 0.
- Wrap case, D=4, base=0x1FFFE, stride=4: addresses 0x1FFFE, 0x00002, 0x00006, 0x0000A; vector slots match mem at those addresses.
- Back-pressure, D=8, stride=2: hold vector_ready=0 for 5 cycles after vector_valid. vector_valid and vector stay stable; one handshake on the ready edge, then IDLE.
- Illegal dimension: dimension=0, then dimension=9, each with start. Single-cycle error pulse each time; rd_en never asserts; busy stays 0.
- Control corner cases: start pulse while busy (new base) is ignored and the original vector is delivered. Reset low during ISSUE at i=2 clears outputs immediately; a new request after release produces a correct vector with no stale slots.
- MEM_LATENCY=3 build, D=5: vector_valid first asserts in cycle 9 and captured data order is correct.
